ahb_cmd_master: RTL
===================

Name: ahb_cmd_master

Overview:
- Upstream AHB bus master that feeds master port 0 of the ahb_test interconnect (the m0_* signals).
- Takes a simple valid/ready command stream of single read/write accesses from a local engine and buffers it in a small FIFO.
- Requests the bus, issues pipelined SINGLE NONSEQ transfers, and returns one response per command, carrying read data and an error flag.
- Handles ERROR, RETRY and SPLIT two-cycle responses.

Parameters:
- CMD_DEPTH, 4, command FIFO entries; power of 2, at least 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- HCLK  in  1  bus clock; all logic on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full; a command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  AW  byte address.
- cmd_size  in  3  HSIZE encoding; only 000, 001 and 010 are legal.
- cmd_wdata  in  DW  write data.
- rsp_valid  out  1  one-cycle pulse per completed command.
- rsp_rdata  out  DW  HRDATA captured for reads; 0 for writes.
- rsp_err  out  1  completion was ERROR.
- HBUSREQ  out  1  bus request to arbiter.
- HGRANT  in  1  arbiter grant.
- HREADY  in  1  bus ready.
- HRESP  in  2  slave response.
- HRDATA  in  DW  read data.
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- HADDR  out  AW  transfer address.
- HWRITE  out  1  transfer direction.
- HSIZE  out  3  transfer size.
- HBURST  out  3  constant SINGLE (000).
- HPROT  out  4  constant 0001 (data access).
- HWDATA  out  DW  write data for the transfer in data phase.

Behaviour:
- Reset values:
  - HBUSREQ=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=1.
  - FIFO empty; retry slot, owner flag, data-phase register and hold flag all cleared.
- Reset mid-transfer: in-flight and queued commands are discarded and produce no response.
- HBUSREQ = FIFO non-empty OR retry slot valid OR data phase valid. Combinational from registered state.
- Ownership:
  - owner flag set on an edge where HGRANT && HREADY.
  - owner flag cleared on an edge where HREADY && !HGRANT.
- Pending source: the retry slot when valid, else the FIFO head. The retry slot always has priority.
- Address phase: when owner && pending valid && !hold, drive HTRANS=NONSEQ with HADDR/HWRITE/HSIZE from the pending source. Otherwise drive HTRANS=IDLE with HADDR/HWRITE/HSIZE = 0.
- Acceptance: on an edge with HTRANS=NONSEQ && HREADY:
  - the source is popped (FIFO head, or retry slot cleared);
  - the command moves to the data-phase register, dp_valid=1;
  - HWDATA register is loaded with its wdata.
  - A new command may be accepted in the same cycle, giving back-to-back pipelining at 1 transfer/cycle.
- Data phase with HREADY=0 and HRESP=OKAY: wait state. Hold everything.
- OKAY completion, on an edge with dp_valid && HREADY && HRESP=OKAY:
  - next cycle rsp_valid=1, rsp_err=0;
  - rsp_rdata = HRDATA if read, else 0.
  - Latency from acceptance to rsp_valid with zero wait states is 2 edges.
- Two-cycle responses (ERROR, RETRY, SPLIT):
  - First cycle (HRESP≠OKAY, HREADY=0): at the edge, set hold. While hold=1, HTRANS=IDLE, which cancels the queued address phase (it stays pending).
  - Second cycle (HREADY=1): at the edge, clear hold and dp_valid.
  - ERROR: rsp_valid=1, rsp_err=1, rsp_rdata=0. The command is dropped.
  - RETRY or SPLIT: copy the data-phase command into the retry slot. No response; it is reissued later.
  - The retry slot is guaranteed free here, since it can only refill after its content was accepted.
- HRESP≠OKAY with HREADY=1 on its first cycle is a protocol violation. Treat it as OKAY completion.
- Grant loss: if the owner flag drops while a command is pending, it stays pending. A data phase already underway still completes normally, because the data bus stays owned.
- FIFO full: cmd_ready=0. A simultaneous push and pop while full is not allowed, since cmd_ready is computed from registered occupancy.
- FIFO empty and no retry: HTRANS=IDLE and HBUSREQ drops the cycle after the last data phase completes.
- Response ordering equals command order, except that a RETRY/SPLIT command completes after its reissue.

Decomposition:
- amba_h package holds:
  - HTRANS_IDLE / HTRANS_NONSEQ;
  - HRESP_OKAY / ERROR / RETRY / SPLIT;
  - HBURST_SINGLE;
  - HSIZE byte/half/word encodings;
  - HPROT_DATA.
- Sub-module ahb_cmd_fifo: synchronous FIFO, width 1+3+AW+DW, depth CMD_DEPTH, with full/empty flags and the same HCLK/HRESET.

Test Plan:
- Single write, grant held, zero wait: push write 0x04006030 / 0x00000001 → HBUSREQ=1, NONSEQ with HADDR=0x04006030, next cycle HWDATA=0x00000001, then rsp_valid with rsp_err=0.
- Back-to-back writes: 0x0400610C/0x00003078, 0x04006100/0x3C001000, 0x04006104/0x38002000, 0x04006110/0x00000003 → four consecutive NONSEQ cycles, HWDATA one cycle behind, four rsp pulses in order, FIFO full stalls cmd_ready at CMD_DEPTH.
- Read with 2 wait states: read 0x04006104, HREADY low for 2 cycles, HRDATA=0x38002000 → rsp_rdata=0x38002000 exactly one response, address bus held IDLE-stable during waits.
- ERROR: write 0x04006030, slave returns two-cycle ERROR → HTRANS IDLE in second cycle, rsp_err=1, following queued command issued afterward.
- RETRY then OKAY: read 0x04006100 gets RETRY → same address reissued before the next FIFO command, single rsp_valid with correct data.
- Grant withdrawal and reset: HGRANT drops mid-queue → HTRANS IDLE, HBUSREQ stays 1, resume on regrant; HRESET asserted mid-burst → all outputs return to reset values immediately.

Source files
------------

// File: rtl/amba_h.sv
// AHB-Lite/AHB2 encodings shared by the command master and its FIFO.
package amba_h;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;
   localparam logic [1:0] HRESP_RETRY = 2'b10;
   localparam logic [1:0] HRESP_SPLIT = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [3:0] HPROT_DATA = 4'b0001;

endpackage

// File: rtl/ahb_cmd_fifo.sv
// Synchronous command FIFO; push is ignored when full, pop is ignored when empty.
module ahb_cmd_fifo #(
   parameter int W     = 68,
   parameter int DEPTH = 4
) (
   input  logic         HCLK,
   input  logic         HRESET,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   cnt_q;
   logic          do_push, do_pop;

   assign full     = (cnt_q == (PW+1)'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem_q[rd_ptr_q];

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge HCLK) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/ahb_cmd_master.sv
// AHB master: buffers single read/write commands, issues pipelined SINGLE NONSEQ
// transfers and returns one response per command, reissuing RETRY/SPLIT transfers.
module ahb_cmd_master
   import amba_h::*;
#(
   parameter int CMD_DEPTH = 4,
   parameter int AW        = 32,
   parameter int DW        = 32
) (
   input  logic          HCLK,
   input  logic          HRESET,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [2:0]    cmd_size,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          HBUSREQ,
   input  logic          HGRANT,
   input  logic          HREADY,
   input  logic [1:0]    HRESP,
   input  logic [DW-1:0] HRDATA,
   output logic [1:0]    HTRANS,
   output logic [AW-1:0] HADDR,
   output logic          HWRITE,
   output logic [2:0]    HSIZE,
   output logic [2:0]    HBURST,
   output logic [3:0]    HPROT,
   output logic [DW-1:0] HWDATA
);

   localparam int CW = 1 + 3 + AW + DW;   // {write, size, addr, wdata}

   logic          owner_q, owner_d;
   logic          hold_q, hold_d;
   logic [1:0]    resp_q, resp_d;
   logic          dp_valid_q, dp_valid_d;
   logic [CW-1:0] dp_cmd_q, dp_cmd_d;
   logic          rty_valid_q, rty_valid_d;
   logic [CW-1:0] rty_cmd_q, rty_cmd_d;
   logic [DW-1:0] hwdata_q, hwdata_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;

   logic          fifo_full, fifo_empty, fifo_pop;
   logic [CW-1:0] fifo_head, pend_cmd;
   logic          pend_valid, addr_active, accept;

   ahb_cmd_fifo #(.W(CW), .DEPTH(CMD_DEPTH)) u_fifo (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .push      (cmd_valid & cmd_ready),
      .push_data ({cmd_write, cmd_size, cmd_addr, cmd_wdata}),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign cmd_ready   = ~fifo_full;
   assign pend_valid  = rty_valid_q | ~fifo_empty;
   assign pend_cmd    = rty_valid_q ? rty_cmd_q : fifo_head;
   assign addr_active = owner_q & pend_valid & ~hold_q;
   assign accept      = addr_active & HREADY;
   assign fifo_pop    = accept & ~rty_valid_q;

   assign HBUSREQ = ~fifo_empty | rty_valid_q | dp_valid_q;
   assign HTRANS  = addr_active ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HADDR   = addr_active ? pend_cmd[DW +: AW] : '0;
   assign HWRITE  = addr_active ? pend_cmd[CW-1] : 1'b0;
   assign HSIZE   = addr_active ? pend_cmd[CW-2 -: 3] : 3'b000;
   assign HBURST  = HBURST_SINGLE;
   assign HPROT   = HPROT_DATA;
   assign HWDATA  = hwdata_q;

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   always_comb begin
      owner_d     = owner_q;
      hold_d      = hold_q;
      resp_d      = resp_q;
      dp_valid_d  = dp_valid_q;
      dp_cmd_d    = dp_cmd_q;
      rty_valid_d = rty_valid_q;
      rty_cmd_d   = rty_cmd_q;
      hwdata_d    = hwdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;

      if (HREADY) owner_d = HGRANT;

      if (dp_valid_q) begin
         if (hold_q) begin
            if (HREADY) begin
               hold_d     = 1'b0;
               dp_valid_d = 1'b0;
               if (resp_q == HRESP_RETRY || resp_q == HRESP_SPLIT) begin
                  rty_valid_d = 1'b1;
                  rty_cmd_d   = dp_cmd_q;
               end else begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end
            end
         end else if (HREADY) begin
            // A non-OKAY response with HREADY high on its first cycle completes as OKAY.
            dp_valid_d  = 1'b0;
            rsp_valid_d = 1'b1;
            if (!dp_cmd_q[CW-1]) rsp_rdata_d = HRDATA;
         end else if (HRESP != HRESP_OKAY) begin
            hold_d = 1'b1;
            resp_d = HRESP;
         end
      end

      // Never coincides with a retry-slot fill: hold keeps HTRANS idle on that edge.
      if (accept) begin
         dp_valid_d  = 1'b1;
         dp_cmd_d    = pend_cmd;
         hwdata_d    = pend_cmd[DW-1:0];
         rty_valid_d = 1'b0;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         owner_q     <= 1'b0;
         hold_q      <= 1'b0;
         resp_q      <= HRESP_OKAY;
         dp_valid_q  <= 1'b0;
         dp_cmd_q    <= '0;
         rty_valid_q <= 1'b0;
         rty_cmd_q   <= '0;
         hwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         owner_q     <= owner_d;
         hold_q      <= hold_d;
         resp_q      <= resp_d;
         dp_valid_q  <= dp_valid_d;
         dp_cmd_q    <= dp_cmd_d;
         rty_valid_q <= rty_valid_d;
         rty_cmd_q   <= rty_cmd_d;
         hwdata_q    <= hwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

endmodule
